pc_fetch_ctrl: RTL and testbench

- Program-counter register and next-PC sequencer for the FETCH stage.
- Consumes the 28-bit shifted jump field produced upstream, plus branch, register-jump and flush redirects.
- Issues one instruction-memory request at a time.
- Presents the fetched instruction and its PC+4 to DECODE through a valid/stall handshake.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/next_pc_sel.sv | 46 ++++
 rtl/pc_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    NPC_SEQ   = 3'd0,
    NPC_BR    = 3'd1,
    NPC_J     = 3'd2,
    NPC_JR    = 3'd3,
    NPC_FLUSH = 3'd4
  } npc_sel_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // Instruction addresses are always word aligned; low bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC target selection: priority mux over redirect sources plus
// detection of misaligned register/flush targets.
module next_pc_sel
  import fetch_pkg::*;
(
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        jr_sel_i,
  input  logic [31:0] jr_target_i,
  input  logic        jump_sel_i,
  input  logic [27:0] jump_i,
  input  logic        branch_taken_i,
  input  logic [15:0] immediate_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] target_o,
  output npc_sel_t    sel_o,
  output logic        misalign_o
);

  logic [31:0] raw_target;

  // Priority: flush > jr > jump > branch > sequential.
  always_comb begin
    raw_target = pc_plus4_i;
    sel_o      = NPC_SEQ;
    if (flush_i) begin
      raw_target = flush_pc_i;
      sel_o      = NPC_FLUSH;
    end else if (jr_sel_i) begin
      raw_target = jr_target_i;
      sel_o      = NPC_JR;
    end else if (jump_sel_i) begin
      raw_target = {pc_plus4_i[31:28], jump_i};
      sel_o      = NPC_J;
    end else if (branch_taken_i) begin
      raw_target = pc_plus4_i + {{14{immediate_i[15]}}, immediate_i, 2'b00};
      sel_o      = NPC_BR;
    end
  end

  assign target_o   = word_align(raw_target);
  // Only register and flush targets can carry nonzero low bits.
  assign misalign_o = ((sel_o == NPC_FLUSH) || (sel_o == NPC_JR)) &&
                      (raw_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC register and sequencer: one outstanding I-mem request,
// holds the fetched instruction for DECODE under a valid/stall handshake.
//
// state   | meaning
// S_IDLE  | after reset, no request yet
// S_FETCH | request outstanding at PC, waiting for IMemReady
// S_VALID | instruction held for DECODE
module pc_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [27:0] Jump,
  input  logic [15:0] Immediate,
  input  logic        JumpSel,
  input  logic        BranchTaken,
  input  logic        JrSel,
  input  logic [31:0] JrTarget,
  input  logic        Flush,
  input  logic [31:0] FlushPc,
  input  logic        Stall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr,
  output logic [31:0] PcPlus4,
  output logic        InstrValid,
  output logic        AddrMisalign
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_q, pend_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        mis_q, mis_d;

  logic [31:0] npc_target;
  npc_sel_t    npc_sel;
  logic        npc_mis;
  logic        flush_hit;

  next_pc_sel u_next_pc_sel (
    .flush_i       (Flush),
    .flush_pc_i    (FlushPc),
    .jr_sel_i      (JrSel),
    .jr_target_i   (JrTarget),
    .jump_sel_i    (JumpSel),
    .jump_i        (Jump),
    .branch_taken_i(BranchTaken),
    .immediate_i   (Immediate),
    .pc_plus4_i    (pcp4_q),
    .target_o      (npc_target),
    .sel_o         (npc_sel),
    .misalign_o    (npc_mis)
  );

  assign flush_hit = (npc_sel == NPC_FLUSH);

  // Next-state and register-update logic for the fetch sequencer.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    instr_d   = instr_q;
    pcp4_d    = pcp4_q;
    mis_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (flush_hit) begin
          pc_d  = npc_target;
          mis_d = npc_mis;
        end
      end
      S_FETCH: begin
        if (IMemReady) begin
          if (flush_hit || pend_q) begin
            // Returning word belongs to the abandoned path; refetch.
            pc_d   = flush_hit ? npc_target : pend_pc_q;
            pend_d = 1'b0;
            mis_d  = flush_hit && npc_mis;
          end else begin
            instr_d = IMemData;
            pcp4_d  = pc_q + 32'd4;
            state_d = S_VALID;
          end
        end else if (flush_hit) begin
          // Address must stay stable until the memory answers.
          pend_d    = 1'b1;
          pend_pc_d = npc_target;
          mis_d     = npc_mis;
        end
      end
      S_VALID: begin
        if (flush_hit || !Stall) begin
          pc_d    = npc_target;
          mis_d   = npc_mis;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= word_align(RESET_PC);
      pend_q    <= 1'b0;
      pend_pc_q <= 32'd0;
      instr_q   <= 32'd0;
      pcp4_q    <= 32'd0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      instr_q   <= instr_d;
      pcp4_q    <= pcp4_d;
      mis_q     <= mis_d;
    end
  end

  assign IMemReq      = (state_q == S_FETCH);
  assign IMemAddr     = pc_q;
  assign Instr        = instr_q;
  assign PcPlus4      = pcp4_q;
  assign InstrValid   = (state_q == S_VALID);
  assign AddrMisalign = mis_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed sequences, a table of
// redirect vectors and a randomized run against a behavioural model.
module tb_pc_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [27:0] Jump;
  logic [15:0] Immediate;
  logic        JumpSel, BranchTaken, JrSel;
  logic [31:0] JrTarget;
  logic        Flush;
  logic [31:0] FlushPc;
  logic        Stall;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic [31:0] Instr, PcPlus4;
  logic        InstrValid, AddrMisalign;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_ctrl #(.RESET_PC(32'h0040_0000)) dut (
    .Clk(Clk), .Reset(Reset), .Jump(Jump), .Immediate(Immediate),
    .JumpSel(JumpSel), .BranchTaken(BranchTaken), .JrSel(JrSel),
    .JrTarget(JrTarget), .Flush(Flush), .FlushPc(FlushPc), .Stall(Stall),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady),
    .IMemData(IMemData), .Instr(Instr), .PcPlus4(PcPlus4),
    .InstrValid(InstrValid), .AddrMisalign(AddrMisalign)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] base;      // PC of the held instruction (PcPlus4 = base+4)
    logic        js;
    logic [27:0] jump;
    logic        br;
    logic [15:0] imm;
    logic        jr;
    logic [31:0] jrt;
    logic [31:0] exp_addr;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[10];

  // Behavioural reference: mode 0 idle, 1 fetching, 2 holding.
  int          m_mode;
  logic [31:0] m_pc, m_pend_pc, m_instr, m_pp4;
  bit          m_pend, m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_redirects();
    JumpSel = 0; BranchTaken = 0; JrSel = 0; Flush = 0;
    Jump = '0; Immediate = '0; JrTarget = '0; FlushPc = '0;
  endtask

  function automatic logic [32:0] model_redirect();
    logic [31:0] t;
    bit mis;
    if (Flush)            t = FlushPc;
    else if (JrSel)       t = JrTarget;
    else if (JumpSel)     t = (m_pp4 & 32'hF000_0000) | {4'h0, Jump};
    else if (BranchTaken) t = m_pp4 + 32'(int'($signed(Immediate)) * 4);
    else                  t = m_pp4 + 32'd4 - 32'd4 + 32'd0;
    if (!Flush && !JrSel && !JumpSel && !BranchTaken) t = m_pp4;
    mis = (Flush || JrSel) && (t % 4 != 0);
    return {mis, t & 32'hFFFF_FFFC};
  endfunction

  task automatic model_step();
    logic [32:0] r;
    bit mis_n;
    if (Reset) begin
      m_mode = 0; m_pc = 32'h0040_0000; m_pend = 0; m_pend_pc = 0;
      m_instr = 0; m_pp4 = 0; m_mis = 0;
      return;
    end
    mis_n = 0;
    r = model_redirect();
    case (m_mode)
      0: begin
        if (Flush) begin m_pc = r[31:0]; mis_n = r[32]; end
        m_mode = 1;
      end
      1: begin
        if (IMemReady) begin
          if (Flush) begin m_pc = r[31:0]; mis_n = r[32]; m_pend = 0; end
          else if (m_pend) begin m_pc = m_pend_pc; m_pend = 0; end
          else begin m_instr = IMemData; m_pp4 = m_pc + 4; m_mode = 2; end
        end else if (Flush) begin
          m_pend = 1; m_pend_pc = r[31:0]; mis_n = r[32];
        end
      end
      default: begin
        if (Flush || !Stall) begin m_pc = r[31:0]; mis_n = r[32]; m_mode = 1; end
      end
    endcase
    m_mis = mis_n;
  endtask

  initial begin
    vecs[0] = '{32'h0040_000C, 1, 28'h010_0020, 0, 16'h0000, 0, 32'h0,         32'h0010_0020, 0};
    vecs[1] = '{32'h0040_000C, 0, 28'h0,        1, 16'hFFFC, 0, 32'h0,         32'h0040_0000, 0};
    vecs[2] = '{32'h0040_000C, 0, 28'h0,        1, 16'hFFFC, 1, 32'h0000_1234, 32'h0000_1234, 0};
    vecs[3] = '{32'h0040_000C, 0, 28'h0,        0, 16'h0000, 1, 32'h0000_1235, 32'h0000_1234, 1};
    vecs[4] = '{32'h0040_000C, 0, 28'h0,        0, 16'h0000, 0, 32'h0,         32'h0040_0010, 0};
    vecs[5] = '{32'hFFFF_FFFC, 0, 28'h0,        0, 16'h0000, 0, 32'h0,         32'h0000_0000, 0};
    vecs[6] = '{32'hA000_0000, 1, 28'hFFF_FFFC, 0, 16'h0000, 0, 32'h0,         32'hAFFF_FFFC, 0};
    vecs[7] = '{32'hFFFF_FFF8, 0, 28'h0,        1, 16'h0002, 0, 32'h0,         32'h0000_0004, 0};
    vecs[8] = '{32'h0040_000C, 1, 28'h000_0040, 1, 16'h0001, 0, 32'h0,         32'h0000_0040, 0};
    vecs[9] = '{32'h0040_000C, 1, 28'h000_0080, 0, 16'h0000, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEC, 1};

    clear_redirects();
    Reset = 1; Stall = 0; IMemReady = 1; IMemData = 32'h2008_0005;

    // Reset release and first-fetch latency.
    tick(); tick();
    chk1("rst_req", IMemReq, 0);
    chk1("rst_valid", InstrValid, 0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_pcp4", PcPlus4, 32'h0);
    chk1("rst_mis", AddrMisalign, 0);
    Reset = 0;
    tick();
    chk1("c1_req", IMemReq, 1);
    chk("c1_addr", IMemAddr, 32'h0040_0000);
    chk1("c1_valid", InstrValid, 0);
    tick();
    chk1("c2_valid", InstrValid, 1);
    chk("c2_instr", Instr, 32'h2008_0005);
    chk("c2_pcp4", PcPlus4, 32'h0040_0004);
    chk1("c2_req", IMemReq, 0);
    tick();
    chk1("c3_req", IMemReq, 1);
    chk("c3_addr", IMemAddr, 32'h0040_0004);

    // Redirect table.
    for (int i = 0; i < 10; i++) begin
      clear_redirects();
      IMemReady = 1; Stall = 1;
      for (int k = 0; k < 4; k++) begin
        if (InstrValid) break;
        tick();
      end
      chk1("reach_valid", InstrValid, 1);
      Flush = 1; FlushPc = vecs[i].base;
      tick();
      Flush = 0; IMemData = 32'hC0DE_0000 | i;
      tick();
      chk1("vec_valid", InstrValid, 1);
      chk("vec_pcp4", PcPlus4, vecs[i].base + 32'd4);
      chk("vec_instr", Instr, 32'hC0DE_0000 | i);
      JumpSel = vecs[i].js; Jump = vecs[i].jump;
      BranchTaken = vecs[i].br; Immediate = vecs[i].imm;
      JrSel = vecs[i].jr; JrTarget = vecs[i].jrt;
      Stall = 0; IMemReady = 0;
      tick();
      chk1("vec_req", IMemReq, 1);
      chk("vec_addr", IMemAddr, vecs[i].exp_addr);
      chk1("vec_mis", AddrMisalign, vecs[i].exp_mis);
      clear_redirects();
      Stall = 1;
      tick();
      chk1("vec_mis_end", AddrMisalign, 0);
      chk("vec_addr_hold", IMemAddr, vecs[i].exp_addr);
    end

    // Flush coinciding with IMemReady drops data; then stall holds everything.
    clear_redirects();
    IMemReady = 1; Flush = 1; FlushPc = 32'h0000_1000; IMemData = 32'h1111_1111;
    tick();
    chk1("fr_valid", InstrValid, 0);
    chk("fr_addr", IMemAddr, 32'h0000_1000);
    Flush = 0; IMemData = 32'h2222_2222;
    tick();
    chk("st_instr0", Instr, 32'h2222_2222);
    Stall = 1; Jump = 28'h000_0F00;
    for (int c = 0; c < 3; c++) begin
      JumpSel = (c % 2 == 0);
      IMemData = 32'h3333_3333;
      tick();
      chk1("st_valid", InstrValid, 1);
      chk1("st_req", IMemReq, 0);
      chk("st_instr", Instr, 32'h2222_2222);
      chk("st_pcp4", PcPlus4, 32'h0000_1004);
    end
    JumpSel = 0; Stall = 0; IMemReady = 0;
    tick();
    chk("st_release_addr", IMemAddr, 32'h0000_1004);

    // Slow memory with a flush arriving mid-request.
    Stall = 1;
    for (int c = 1; c <= 4; c++) begin
      Flush = (c == 2); FlushPc = 32'h8000_0180;
      tick();
      chk("slow_addr", IMemAddr, 32'h0000_1004);
      chk1("slow_req", IMemReq, 1);
      chk1("slow_valid", InstrValid, 0);
    end
    Flush = 0; IMemReady = 1; IMemData = 32'h4444_4444;
    tick();
    chk1("slow_drop_valid", InstrValid, 0);
    chk("slow_new_addr", IMemAddr, 32'h8000_0180);
    IMemData = 32'h5555_5555;
    tick();
    chk("slow_instr", Instr, 32'h5555_5555);
    chk("slow_pcp4", PcPlus4, 32'h8000_0184);

    // Reset while holding a stalled instruction.
    Reset = 1;
    tick();
    chk1("rv_valid", InstrValid, 0);
    chk1("rv_req", IMemReq, 0);
    chk("rv_addr", IMemAddr, 32'h0040_0000);
    chk("rv_instr", Instr, 32'h0);
    Reset = 0;

    // Randomized run against the reference model.
    for (int n = 0; n < 3000; n++) begin
      Reset       = (n == 0) || ($urandom_range(63) == 0);
      Flush       = ($urandom_range(7) == 0);
      FlushPc     = $urandom;
      Stall       = ($urandom_range(2) == 0);
      IMemReady   = $urandom_range(1);
      IMemData    = $urandom;
      JrSel       = ($urandom_range(5) == 0);
      JrTarget    = $urandom;
      JumpSel     = ($urandom_range(3) == 0);
      Jump        = 28'($urandom);
      BranchTaken = ($urandom_range(2) == 0);
      Immediate   = 16'($urandom);
      model_step();
      tick();
      chk1("rnd_req", IMemReq, m_mode == 1);
      chk("rnd_addr", IMemAddr, m_pc);
      chk1("rnd_valid", InstrValid, m_mode == 2);
      chk("rnd_instr", Instr, m_instr);
      chk("rnd_pcp4", PcPlus4, m_pp4);
      chk1("rnd_mis", AddrMisalign, m_mis);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
